// File: rtl/timer_intc_if.sv
// timer_intc_if: CPU/software-facing signal bundle of the timer interrupt collector.
//   irq_src       : raw timer interrupt lines {OVI3..0, CMIB3..0, CMIA3..0}
//   en_wr/en_wdata: enable-register write strobe and data; en_mask reads it back
//   pend_clr_wr/pend_clr_data: software clear of pending/overrun bits
//   pend, ovr     : pending and sticky overrun flags
//   irq_req/irq_vec/irq_ack: request/vector/acknowledge handshake to the CPU
// Modports: master = stimulus/CPU side, slave = timer_intc.
interface timer_intc_if #(
    parameter int unsigned NUM_SRC   = 12,
    parameter int unsigned VEC_WIDTH = 4
);
    logic [NUM_SRC-1:0]   irq_src;
    logic                 en_wr;
    logic [NUM_SRC-1:0]   en_wdata;
    logic [NUM_SRC-1:0]   en_mask;
    logic                 pend_clr_wr;
    logic [NUM_SRC-1:0]   pend_clr_data;
    logic [NUM_SRC-1:0]   pend;
    logic [NUM_SRC-1:0]   ovr;
    logic                 irq_req;
    logic [VEC_WIDTH-1:0] irq_vec;
    logic                 irq_ack;

    modport master (
        output irq_src, en_wr, en_wdata, pend_clr_wr, pend_clr_data, irq_ack,
        input  en_mask, pend, ovr, irq_req, irq_vec
    );

    modport slave (
        input  irq_src, en_wr, en_wdata, pend_clr_wr, pend_clr_data, irq_ack,
        output en_mask, pend, ovr, irq_req, irq_vec
    );
endinterface

// File: rtl/timer_intc.sv
// timer_intc: interrupt collector for the 8-bit timer.
// Latches rising edges of the twelve timer interrupt lines into pending bits,
// flags overruns, masks with a per-source enable and hands one request at a
// time to the CPU through a req/vec/ack handshake (IDLE -> REQ -> GAP).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : timer_intc_if.slave (irq_src, en_*, pend_clr_*, pend, ovr, irq_*)
// Optional feature: define TIMER_INTC_RR_EN for round-robin arbitration
// starting after the last acknowledged vector; otherwise lowest index wins.
module timer_intc #(
    parameter int unsigned NUM_SRC   = 12,
    parameter int unsigned VEC_WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    timer_intc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t               state, state_n;
    logic [NUM_SRC-1:0]   src_d;
    logic [NUM_SRC-1:0]   edge_v;
    logic [NUM_SRC-1:0]   sw_clr;
    logic [NUM_SRC-1:0]   ack_clr;
    logic [NUM_SRC-1:0]   pend_q, ovr_q, en_q;
    logic [NUM_SRC-1:0]   req_bits;
    logic                 grant_any;
    logic [VEC_WIDTH-1:0] grant_idx;
    logic [VEC_WIDTH-1:0] vec_q;
    logic                 load_vec;
    logic                 ack_fire;

    assign edge_v   = bus.irq_src & ~src_d;
    assign sw_clr   = {NUM_SRC{bus.pend_clr_wr}} & bus.pend_clr_data;
    assign ack_fire = (state == REQ) && bus.irq_ack;
    assign ack_clr  = ack_fire ? (NUM_SRC'(1) << vec_q) : '0;
    assign req_bits = pend_q & en_q;
    assign grant_any = |req_bits;

`ifdef TIMER_INTC_RR_EN
    logic [VEC_WIDTH-1:0] last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= '0;
        else if (ack_fire)
            last_q <= vec_q;
    end

    // Walk offsets from farthest to nearest so the source right after
    // last_q is written last and therefore has priority.
    always_comb begin
        grant_idx = '0;
        for (int unsigned k = NUM_SRC; k > 0; k--) begin
            int unsigned idx;
            idx = (int unsigned'(last_q) + k) % NUM_SRC;
            if (req_bits[idx])
                grant_idx = VEC_WIDTH'(idx);
        end
    end
`else
    // Descending scan: the lowest set index is written last and wins.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (req_bits[i-1])
                grant_idx = VEC_WIDTH'(i - 1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_d  <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
            en_q   <= '0;
        end else begin
            src_d  <= bus.irq_src;
            // Set has priority over every clear so no edge is lost.
            pend_q <= edge_v | (pend_q & ~(sw_clr | ack_clr));
            ovr_q  <= (edge_v & pend_q) | (ovr_q & ~sw_clr);
            if (bus.en_wr)
                en_q <= bus.en_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load_vec = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_n  = REQ;
                    load_vec = 1'b1;
                end
            end
            REQ:     if (bus.irq_ack) state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vec_q <= '0;
        else if (load_vec)
            vec_q <= grant_idx;
    end

    assign bus.irq_req = (state == REQ);
    assign bus.irq_vec = vec_q;
    assign bus.pend    = pend_q;
    assign bus.ovr     = ovr_q;
    assign bus.en_mask = en_q;
endmodule

// File: tb/tb_timer_intc.sv
module tb_timer_intc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned passes = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;

`ifdef TIMER_INTC_RR_EN
    localparam logic [3:0] PAIR_FIRST  = 4'd8;
    localparam logic [3:0] PAIR_SECOND = 4'd0;
`else
    localparam logic [3:0] PAIR_FIRST  = 4'd0;
    localparam logic [3:0] PAIR_SECOND = 4'd8;
`endif

    timer_intc_if #(.NUM_SRC(12), .VEC_WIDTH(4)) bus ();

    timer_intc #(.NUM_SRC(12), .VEC_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mask(input logic [11:0] m);
        bus.en_wr = 1'b1;
        bus.en_wdata = m;
        tick();
        bus.en_wr = 1'b0;
    endtask

    task automatic pulse(input logic [11:0] s);
        bus.irq_src = s;
        tick();
        bus.irq_src = '0;
    endtask

    task automatic sw_clear(input logic [11:0] d);
        bus.pend_clr_wr = 1'b1;
        bus.pend_clr_data = d;
        tick();
        bus.pend_clr_wr = 1'b0;
        bus.pend_clr_data = '0;
    endtask

    initial begin
        bus.irq_src = '0;
        bus.en_wr = 1'b0;
        bus.en_wdata = '0;
        bus.pend_clr_wr = 1'b0;
        bus.pend_clr_data = '0;
        bus.irq_ack = 1'b0;
        #22 rst = 1'b0;
        tick();

        chk("rst_en_mask", 32'(bus.en_mask), 32'h000);
        chk("rst_pend", 32'(bus.pend), 32'h000);
        chk("rst_ovr", 32'(bus.ovr), 32'h000);
        chk("rst_req", 32'(bus.irq_req), 32'd0);
        chk("rst_vec", 32'(bus.irq_vec), 32'd0);

        // Simultaneous sources 0 and 8, right after reset (last grant = 0).
        write_mask(12'hFFF);
        chk("mask_fff", 32'(bus.en_mask), 32'hFFF);
        pulse(12'h101);
        chk("pair_pend", 32'(bus.pend), 32'h101);
        chk("pair_req_lat", 32'(bus.irq_req), 32'd0);
        tick();
        chk("pair_req1", 32'(bus.irq_req), 32'd1);
        chk("pair_vec1", 32'(bus.irq_vec), 32'(PAIR_FIRST));
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("pair_gap_req", 32'(bus.irq_req), 32'd0);
        chk("pair_pend_after1", 32'(bus.pend), 32'h101 & ~(32'd1 << PAIR_FIRST));
        chk("pair_gap_vec_hold", 32'(bus.irq_vec), 32'(PAIR_FIRST));
        tick();
        chk("pair_idle_req", 32'(bus.irq_req), 32'd0);
        tick();
        chk("pair_req2", 32'(bus.irq_req), 32'd1);
        chk("pair_vec2", 32'(bus.irq_vec), 32'(PAIR_SECOND));
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        tick();
        chk("pair_done_req", 32'(bus.irq_req), 32'd0);
        chk("pair_done_pend", 32'(bus.pend), 32'h000);

        // Single pulse on CMIB0 (index 4).
        pulse(12'h010);
        chk("s4_pend", 32'(bus.pend), 32'h010);
        chk("s4_req_early", 32'(bus.irq_req), 32'd0);
        tick();
        chk("s4_req", 32'(bus.irq_req), 32'd1);
        chk("s4_vec", 32'(bus.irq_vec), 32'd4);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("s4_gap_req", 32'(bus.irq_req), 32'd0);
        chk("s4_pend_clr", 32'(bus.pend), 32'h000);
        tick();
        chk("s4_idle_req", 32'(bus.irq_req), 32'd0);
        tick();
        chk("s4_stay_low", 32'(bus.irq_req), 32'd0);

        // Masked source 11, stray ack ignored, then enable.
        write_mask(12'h000);
        pulse(12'h800);
        tick();
        tick();
        chk("m11_pend", 32'(bus.pend), 32'h800);
        chk("m11_no_req", 32'(bus.irq_req), 32'd0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("stray_ack_pend", 32'(bus.pend), 32'h800);
        write_mask(12'h800);
        chk("m11_req_early", 32'(bus.irq_req), 32'd0);
        tick();
        chk("m11_req", 32'(bus.irq_req), 32'd1);
        chk("m11_vec", 32'(bus.irq_vec), 32'd11);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        chk("m11_pend_clr", 32'(bus.pend), 32'h000);

        // Overrun on index 2 with arbitration masked off.
        write_mask(12'h000);
        pulse(12'h004);
        tick();
        pulse(12'h004);
        tick();
        chk("ovr_pend", 32'(bus.pend), 32'h004);
        chk("ovr_set", 32'(bus.ovr), 32'h004);
        sw_clear(12'h004);
        chk("clr_pend", 32'(bus.pend), 32'h000);
        chk("clr_ovr", 32'(bus.ovr), 32'h000);
        pulse(12'h004);
        tick();
        chk("one_edge_no_ovr", 32'(bus.ovr), 32'h000);
        bus.irq_src = 12'h004;
        sw_clear(12'h004);
        bus.irq_src = '0;
        chk("set_wins_pend", 32'(bus.pend), 32'h004);
        chk("set_wins_ovr", 32'(bus.ovr), 32'h004);
        sw_clear(12'h004);
        chk("final_clr", 32'(bus.pend | bus.ovr), 32'h000);

        // Index 3: edge in the ack cycle, request not retracted.
        write_mask(12'h008);
        pulse(12'h008);
        tick();
        chk("s3_req", 32'(bus.irq_req), 32'd1);
        chk("s3_vec", 32'(bus.irq_vec), 32'd3);
        bus.irq_src = 12'h008;
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_src = '0;
        bus.irq_ack = 1'b0;
        chk("s3_gap_req", 32'(bus.irq_req), 32'd0);
        chk("s3_pend_kept", 32'(bus.pend), 32'h008);
        tick();
        chk("s3_idle_req", 32'(bus.irq_req), 32'd0);
        tick();
        chk("s3_req_again", 32'(bus.irq_req), 32'd1);
        chk("s3_vec_again", 32'(bus.irq_vec), 32'd3);
        write_mask(12'h000);
        chk("s3_mask_keep_req", 32'(bus.irq_req), 32'd1);
        sw_clear(12'h008);
        chk("s3_swclr_keep_req", 32'(bus.irq_req), 32'd1);
        chk("s3_swclr_pend", 32'(bus.pend), 32'h000);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("s3_final_req", 32'(bus.irq_req), 32'd0);

        // Async reset mid-request, then a held-high source.
        write_mask(12'hFFF);
        bus.irq_src = 12'h020;
        tick();
        tick();
        chk("pre_rst_req", 32'(bus.irq_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", 32'(bus.irq_req), 32'd0);
        chk("async_pend", 32'(bus.pend), 32'h000);
        chk("async_mask", 32'(bus.en_mask), 32'h000);
        #10 rst = 1'b0;
        tick();
        chk("held_edge", 32'(bus.pend), 32'h020);
        sw_clear(12'h020);
        tick();
        tick();
        chk("held_single", 32'(bus.pend), 32'h000);
        chk("held_no_ovr", 32'(bus.ovr), 32'h000);
        bus.irq_src = '0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/timer_intc.md
Name: timer_intc

Overview:
Interrupt collector downstream of the 8-bit timer.
- Consumes the twelve timer interrupt outputs: CMIA0-3, CMIB0-3, OVI0-3.
- Latches each source's rising edge into a pending bit, masks pending bits with a per-source enable, and arbitrates one request at a time to the CPU.
- The CPU side sees a request/vector/acknowledge handshake.

Parameters:
NUM_SRC, 12, number of interrupt sources; bit index = {OVI3,OVI2,OVI1,OVI0,CMIB3,CMIB2,CMIB1,CMIB0,CMIA3,CMIA2,CMIA1,CMIA0} from MSB to LSB.
VEC_WIDTH, 4, width of the vector output; must be at least ceil(log2(NUM_SRC)).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
irq_src  input  NUM_SRC  raw timer interrupt lines; level inputs, synchronous to clk.
en_wr  input  1  write strobe for the enable register.
en_wdata  input  NUM_SRC  new enable mask, loaded when en_wr=1.
en_mask  output  NUM_SRC  current enable register.
pend_clr_wr  input  1  software pending-clear strobe.
pend_clr_data  input  NUM_SRC  1-bits select pending/overrun bits to clear.
pend  output  NUM_SRC  pending flags.
ovr  output  NUM_SRC  sticky overrun flags: an edge arrived while that pending bit was already 1.
irq_req  output  1  interrupt request to CPU.
irq_vec  output  VEC_WIDTH  index of the granted source; valid while irq_req=1.
irq_ack  input  1  CPU acknowledge; meaningful only while irq_req=1.

Behaviour:
Reset:
- en_mask, pend, ovr, the internal irq_src delay register and irq_vec all go to 0; irq_req=0; FSM goes to IDLE.
- Reset asserted mid-handshake drops irq_req immediately (asynchronous).

Edge detect:
- src_d <= irq_src each cycle.
- edge = irq_src & ~src_d.
- A source already high when reset releases produces one edge on the first clock.

Pending update, per bit, each cycle:
- edge=1 -> pend <= 1. If pend was already 1, ovr <= 1.
- Clear terms are pend_clr_wr & pend_clr_data[i], and ack-clear of the granted index.
- Any clear term -> pend <= 0, unless edge is set in the same cycle; set wins, so no event is lost.
- pend_clr also clears ovr; a simultaneous overrun set wins.
- Pending bits latch regardless of en_mask. The mask gates arbitration only.

en_mask:
- Loads en_wdata when en_wr=1; otherwise holds.
- The new mask takes effect for arbitration on the following cycle.

FSM states IDLE, REQ, GAP:
- IDLE: if |(pend & en_mask), latch irq_vec = lowest set index of (pend & en_mask), set irq_req=1 and go to REQ. Otherwise stay.
- REQ: irq_req=1; irq_vec held stable. A request is never retracted: masking or software-clearing the granted bit during REQ does not drop irq_req. On irq_ack=1: clear pend[irq_vec], irq_req <= 0, go to GAP.
- GAP: irq_req=0 for exactly one cycle, then IDLE. This guarantees a deassertion between back-to-back requests.

Handshake rules:
- irq_ack while irq_req=0 is ignored.
- irq_vec keeps its last value when irq_req=0.

Latency:
- A source rising before clock edge k sets pend at edge k.
- irq_req is high after edge k+1, i.e. 2 cycles from source to request.
- Minimum spacing from ack to the next irq_req is 2 cycles (REQ->GAP->IDLE->REQ; the request registers on leaving IDLE).

Arbitration:
- Fixed priority; lowest index wins, so CMIA0 is highest priority and OVI3 lowest.

Optional Feature:
Macro TIMER_INTC_RR_EN.
- Defined: round-robin arbitration. An internal last-grant pointer (reset 0) is set to irq_vec on each ack. Arbitration searches from (last+1) mod NUM_SRC upward with wrap, and the first enabled pending bit wins.
- Undefined: fixed lowest-index priority as above; the pointer logic is absent.

Test Plan:
- Reset, en_wdata=0xFFF, pulse irq_src[4] (CMIA... index 4 = CMIB0) one cycle -> pend[4]=1 next edge; irq_req=1 two cycles after the rise with irq_vec=4; irq_ack one cycle -> pend[4]=0, irq_req=0 for one GAP cycle, then stays low.
- With en_mask=0xFFF, raise irq_src[0] and irq_src[8] together -> vec 0 first. After its ack, vec 8 is issued 2 cycles later. With TIMER_INTC_RR_EN defined and last grant = 0, a repeat of both gives vec 8 first.
- en_mask=0x000, pulse irq_src[11] -> pend[11]=1, irq_req stays 0. Write en_wdata=0x800 -> irq_req=1 with vec 11 two cycles after the write.
- Two pulses on irq_src[2] before any ack -> ovr[2]=1. pend_clr_wr with data 0x004 -> pend[2]=0 and ovr[2]=0. An edge on bit 2 in the same cycle as the clear -> pend[2]=1 and ovr[2]=1.
- During REQ with vec=3: new edge on irq_src[3] in the ack cycle -> pend[3] stays 1 and a new request with vec=3 follows after GAP.
- Assert rst while irq_req=1 -> irq_req, pend and en_mask go to 0 immediately, without a clock edge. After release, a source held high produces a single edge.
